// File: rtl/prod_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// prod_accumulator_pkg
//   Shared definitions for the product accumulator stage that sits directly
//   downstream of the 4x4 array multiplier.
//
//   Contents:
//     acc_state_t : stage state (ACCUM = gathering products, HOLD = result
//                   waiting for the consumer)
//     MAX_PROD    : largest product the 4x4 multiplier can emit, used by
//                   assertions and stimulus generators
//     grp_len_ok  : helper that tells whether a count field of a given width
//                   can hold the group length
// -----------------------------------------------------------------------------
package prod_accumulator_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // (2^4 - 1)^2: product of the two largest 4-bit operands.
  localparam int MAX_PROD = (2**4 - 1) * (2**4 - 1);

  // True when a CNT_W-bit field can represent the value len.
  function automatic bit grp_len_ok(input int cnt_w, input int len);
    return (len >= 1) && (len < (1 << cnt_w));
  endfunction

endpackage : prod_accumulator_pkg

// File: rtl/prod_accumulator.sv
// -----------------------------------------------------------------------------
// prod_accumulator
//   Sums groups of up to LEN unsigned products arriving on a valid/ready
//   stream and presents each completed group sum on a registered valid/ready
//   output. A group closes on the LEN-th accepted product or on an accepted
//   product flagged with in_last. A new group may start in the same cycle the
//   previous result is taken, so the stage sustains one product per cycle.
//
//   Ports:
//     clk        in   1       rising-edge clock
//     rst_n      in   1       asynchronous active-low reset
//     flush      in   1       discard partial group (ignored while a result
//                             is pending)
//     in_valid   in   1       product valid
//     in_ready   out  1       stage can accept a product this cycle
//     in_prod    in   PROD_W  unsigned product
//     in_last    in   1       product closes the current group early
//     out_valid  out  1       group result valid (registered)
//     out_ready  in   1       consumer takes the result
//     out_sum    out  ACC_W   group sum, modulo 2^ACC_W
//     out_count  out  CNT_W   number of products in the group (1..LEN)
//     out_ovf    out  1       some addition in the group carried out of ACC_W
// -----------------------------------------------------------------------------
module prod_accumulator
  import prod_accumulator_pkg::*;
#(
  parameter int PROD_W = 8,
  parameter int LEN    = 4,
  parameter int ACC_W  = 10,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  acc_state_t       state_reg,     state_next;
  logic [ACC_W-1:0] acc_reg,       acc_next;
  logic [CNT_W-1:0] cnt_reg,       cnt_next;
  logic             ovf_reg,       ovf_next;
  logic             out_valid_reg, out_valid_next;
  logic [ACC_W-1:0] out_sum_reg,   out_sum_next;
  logic [CNT_W-1:0] out_count_reg, out_count_next;
  logic             out_ovf_reg,   out_ovf_next;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic accept;
  logic take;

  // While a result is pending the only way to free the stage is the consumer
  // taking it, so readiness depends combinationally on out_ready alone.
  assign in_ready = (state_reg == ACCUM) | out_ready;
  assign accept   = in_valid & in_ready;
  assign take     = out_valid_reg & out_ready;

  // ---------------------------------------------------------------------------
  // Group datapath
  //   In HOLD the partial-group registers are already clear, but the base is
  //   forced to zero anyway so an accept in HOLD always starts a fresh group
  //   regardless of what the registers hold.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] base_acc;
  logic [CNT_W-1:0] base_cnt;
  logic             base_ovf;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] grp_sum;
  logic [CNT_W-1:0] grp_cnt;
  logic             grp_ovf;
  logic             grp_close;

  assign base_acc  = (state_reg == ACCUM) ? acc_reg : '0;
  assign base_cnt  = (state_reg == ACCUM) ? cnt_reg : '0;
  assign base_ovf  = (state_reg == ACCUM) ? ovf_reg : 1'b0;

  // One extra bit captures the carry out of the ACC_W-bit accumulator.
  assign prod_ext  = (ACC_W+1)'(in_prod);
  assign sum_ext   = {1'b0, base_acc} + prod_ext;
  assign grp_sum   = sum_ext[ACC_W-1:0];
  assign grp_ovf   = base_ovf | sum_ext[ACC_W];
  assign grp_cnt   = base_cnt + CNT_W'(1);
  assign grp_close = (grp_cnt == CNT_W'(LEN)) | in_last;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    ovf_next       = ovf_reg;
    out_valid_next = out_valid_reg;
    out_sum_next   = out_sum_reg;
    out_count_next = out_count_reg;
    out_ovf_next   = out_ovf_reg;

    unique case (state_reg)
      ACCUM: begin
        if (flush) begin
          // Partial group dropped; a same-cycle product is dropped with it.
          acc_next = '0;
          cnt_next = '0;
          ovf_next = 1'b0;
        end else if (accept) begin
          if (grp_close) begin
            out_sum_next   = grp_sum;
            out_count_next = grp_cnt;
            out_ovf_next   = grp_ovf;
            out_valid_next = 1'b1;
            state_next     = HOLD;
            acc_next       = '0;
            cnt_next       = '0;
            ovf_next       = 1'b0;
          end else begin
            acc_next = grp_sum;
            cnt_next = grp_cnt;
            ovf_next = grp_ovf;
          end
        end
      end

      HOLD: begin
        // flush is deliberately ignored here so a pending result survives.
        // accept implies take in this state since in_ready == out_ready.
        if (take) begin
          if (accept && grp_close) begin
            // Single-product group: the output slot refills back-to-back.
            out_sum_next   = grp_sum;
            out_count_next = grp_cnt;
            out_ovf_next   = grp_ovf;
            out_valid_next = 1'b1;
            state_next     = HOLD;
            acc_next       = '0;
            cnt_next       = '0;
            ovf_next       = 1'b0;
          end else if (accept) begin
            acc_next       = grp_sum;
            cnt_next       = grp_cnt;
            ovf_next       = grp_ovf;
            out_valid_next = 1'b0;
            state_next     = ACCUM;
          end else begin
            out_valid_next = 1'b0;
            state_next     = ACCUM;
          end
        end
      end

      default: begin
        state_next     = ACCUM;
        acc_next       = '0;
        cnt_next       = '0;
        ovf_next       = 1'b0;
        out_valid_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ACCUM;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_count_reg <= '0;
      out_ovf_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      ovf_reg       <= ovf_next;
      out_valid_reg <= out_valid_next;
      out_sum_reg   <= out_sum_next;
      out_count_reg <= out_count_next;
      out_ovf_reg   <= out_ovf_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_count = out_count_reg;
  assign out_ovf   = out_ovf_reg;

  // ---------------------------------------------------------------------------
  // Assertions
  // ---------------------------------------------------------------------------
  a_count_range : assert property (
    @(posedge clk) disable iff (!rst_n)
      out_valid_reg |-> (out_count_reg >= CNT_W'(1)) && (out_count_reg <= CNT_W'(LEN))
  );

  a_out_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
      (out_valid_reg && !out_ready) |=>
        (out_valid_reg && $stable(out_sum_reg) && $stable(out_count_reg) && $stable(out_ovf_reg))
  );

  a_hold_has_result : assert property (
    @(posedge clk) disable iff (!rst_n)
      (state_reg == HOLD) == out_valid_reg
  );

  a_len_fits : assert property (
    @(posedge clk) disable iff (!rst_n) grp_len_ok(CNT_W, LEN)
  );

endmodule : prod_accumulator
